// File: rtl/axis_fifo_arbiter_pkg.sv
// Shared helpers for the AXI-Stream FIFO arbiter and its round-robin selector.
package axis_fifo_arbiter_pkg;

  // Ceiling log2. Returns 0 for value <= 1. Callers add headroom where they need it.
  function automatic int clogb2(input int value);
    int v;
    int result;
    v      = value - 1;
    result = 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_fifo_arbiter_if.sv
// Stream bundle around the arbiter: NUM_PORTS packed requesters in, one FIFO-facing stream out.
// The master modport is the arbiter's view (it masters the FIFO stream); slave is the surroundings.
interface axis_fifo_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int BUS_WIDTH  = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1
);
  logic [NUM_PORTS-1:0]              s_axis_tvalid;
  logic [NUM_PORTS-1:0]              s_axis_tready;
  logic [NUM_PORTS*BUS_WIDTH*8-1:0]  s_axis_tdata;
  logic [NUM_PORTS*BUS_WIDTH-1:0]    s_axis_tkeep;
  logic [NUM_PORTS-1:0]              s_axis_tlast;
  logic [NUM_PORTS*USER_WIDTH-1:0]   s_axis_tuser;
  logic [NUM_PORTS*DEST_WIDTH-1:0]   s_axis_tdest;

  logic                              m_axis_tvalid;
  logic                              m_axis_tready;
  logic [BUS_WIDTH*8-1:0]            m_axis_tdata;
  logic [BUS_WIDTH-1:0]              m_axis_tkeep;
  logic                              m_axis_tlast;
  logic [USER_WIDTH-1:0]             m_axis_tuser;
  logic [DEST_WIDTH-1:0]             m_axis_tdest;

  logic [NUM_PORTS-1:0]              grant;
  logic                              busy;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tdest,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest,
    input  m_axis_tready,
    output grant, busy
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tdest,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest,
    output m_axis_tready,
    input  grant, busy
  );
endinterface

// File: rtl/axis_fifo_arbiter_rr_select.sv
// Combinational round-robin pick: first requester strictly after i_ptr, scanning upward with wrap.
// Generic enough to be shared by any scheduler that keeps a last-grant pointer.
module axis_arb_rr_select
  import axis_fifo_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = clogb2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);
  logic w_found;

  // Two passes: ports above the pointer first, then wrap to the ports at or below it.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && i_req[j] && (j > int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && i_req[j] && (j <= int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
    o_valid = w_found;
  end
endmodule

// File: rtl/axis_fifo_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write stream between NUM_PORTS requesters.
// Grant is held for a whole packet (or up to BURST_LEN beats); one idle cycle separates grants.
module axis_fifo_arbiter
  import axis_fifo_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int BUS_WIDTH   = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEST_WIDTH  = 1,
  parameter int PACKET_MODE = 1,
  parameter int BURST_LEN   = 16
) (
  input  logic                aclk,
  input  logic                arst,
  axis_fifo_arbiter_if.master bus
);
  localparam int DATA_W = BUS_WIDTH * 8;
  localparam int IDX_W  = clogb2(NUM_PORTS);
  localparam int CNT_W  = clogb2(BURST_LEN) + 1;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_PORTS - 1);
  localparam logic             BURST_CAP = (PACKET_MODE == 0);

  logic                 r_state;
  logic                 w_state_next;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] w_grant_next;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;

  logic [NUM_PORTS-1:0] w_sel_grant;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_sel_valid;
  logic                 w_g_tvalid;
  logic                 w_g_tlast;
  logic                 w_beat;
  logic                 w_release;

  axis_arb_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .i_req   (bus.s_axis_tvalid),
    .i_ptr   (r_ptr),
    .o_grant (w_sel_grant),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  // r_grant is all-zero outside ACTIVE, so these are naturally gated by state.
  assign w_g_tvalid = |(bus.s_axis_tvalid & r_grant);
  assign w_g_tlast  = |(bus.s_axis_tlast & r_grant);
  assign w_beat     = w_g_tvalid & bus.m_axis_tready;
  assign w_release  = w_beat & (w_g_tlast | (BURST_CAP & (r_cnt == CNT_LAST)));

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= PTR_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_state_next = ST_ACTIVE;
          w_grant_next = w_sel_grant;
          w_ptr_next   = w_sel_idx;
          w_cnt_next   = '0;
        end
      end
      ST_ACTIVE: begin
        if (w_release) begin
          w_state_next = ST_IDLE;
          w_grant_next = '0;
          w_cnt_next   = '0;
        end else if (w_beat) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.m_axis_tdata = '0;
    bus.m_axis_tkeep = '0;
    bus.m_axis_tuser = '0;
    bus.m_axis_tdest = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_grant[k]) begin
        bus.m_axis_tdata = bus.s_axis_tdata[k*DATA_W +: DATA_W];
        bus.m_axis_tkeep = bus.s_axis_tkeep[k*BUS_WIDTH +: BUS_WIDTH];
        bus.m_axis_tuser = bus.s_axis_tuser[k*USER_WIDTH +: USER_WIDTH];
        bus.m_axis_tdest = bus.s_axis_tdest[k*DEST_WIDTH +: DEST_WIDTH];
      end
    end
    bus.m_axis_tvalid = w_g_tvalid;
    bus.m_axis_tlast  = w_g_tlast;
    bus.s_axis_tready = r_grant & {NUM_PORTS{bus.m_axis_tready}};
    bus.grant         = r_grant;
    bus.busy          = (r_state == ST_ACTIVE);
  end
endmodule
